// File: rtl/tx_pkg.sv
// Shared constants and types for the UDP transmit packet arbiter.
// Port numbering follows the logical stream assignment of the radio.
package tx_pkg;

  localparam int unsigned SEQ_W  = 32;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned PORT_W = 4;

  localparam int unsigned PORT_RESPONSE = 0;
  localparam int unsigned PORT_HPCC     = 1;
  localparam int unsigned PORT_DDC0     = 2;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StDrain,
    StDone
  } state_e;

  function automatic logic [PORT_W-1:0] port_id(input int p);
    return PORT_W'(p);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search over the shared ports 2..NUM_PORTS-1, starting just above rr_ptr_i.
// Picks the requesting port with the smallest upward distance from rr_ptr_i, with wrap.
module rr_pick
  import tx_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 8
) (
  input  logic [NUM_PORTS-1:2] req_i,
  input  logic [PORT_W-1:0]    rr_ptr_i,
  output logic                 valid_o,
  output logic [PORT_W-1:0]    index_o
);

  localparam int NumRr = int'(NUM_PORTS) - 2;

  int best_dist;
  int cur_dist;

  always_comb begin
    valid_o   = 1'b0;
    index_o   = '0;
    best_dist = NumRr;
    cur_dist  = 0;
    for (int k = 2; k < int'(NUM_PORTS); k++) begin
      // rr_ptr+1 has distance 0, rr_ptr itself has distance NumRr-1
      cur_dist = k - int'(rr_ptr_i) - 1;
      if (cur_dist < 0) begin
        cur_dist = cur_dist + NumRr;
      end
      if (req_i[k] && (cur_dist < best_dist)) begin
        best_dist = cur_dist;
        valid_o   = 1'b1;
        index_o   = port_id(k);
      end
    end
  end

endmodule

// File: rtl/tx_packet_arbiter.sv
// Selects the next logical port to hand to send_data and stamps it with a per-port
// sequence number. Port 0 beats port 1 beats round-robin over the remaining ports.
module tx_packet_arbiter
  import tx_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 8,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       req,
  input  logic [LEN_W*NUM_PORTS-1:0] len_in,
  input  logic                       seq_reset,
  input  logic                       udp_tx_active,
  input  logic                       busy,
  output logic                       send,
  output logic [PORT_W-1:0]          port_ID,
  output logic [LEN_W-1:0]           udp_tx_length,
  output logic [SEQ_W-1:0]           sequence_number,
  output logic [NUM_PORTS-1:0]       grant,
  output logic                       timeout_err
);

  localparam logic [31:0] TmoLast = 32'(TIMEOUT - 1);

  state_e                          state_q;
  logic [PORT_W-1:0]               rr_ptr_q;
  logic [NUM_PORTS-1:0][SEQ_W-1:0] seq_q;
  logic [31:0]                     tmo_q;
  logic                            seq_sup_q;

  logic              rr_valid;
  logic [PORT_W-1:0] rr_idx;
  logic              win_valid;
  logic [PORT_W-1:0] win_idx;
  logic [LEN_W-1:0]  win_len;
  logic [SEQ_W-1:0]  win_seq;

  rr_pick #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_pick (
    .req_i   (req[NUM_PORTS-1:2]),
    .rr_ptr_i(rr_ptr_q),
    .valid_o (rr_valid),
    .index_o (rr_idx)
  );

  always_comb begin
    win_valid = 1'b1;
    win_idx   = port_id(PORT_RESPONSE);
    if (req[PORT_RESPONSE]) begin
      win_idx = port_id(PORT_RESPONSE);
    end else if (req[PORT_HPCC]) begin
      win_idx = port_id(PORT_HPCC);
    end else begin
      win_valid = rr_valid;
      win_idx   = rr_idx;
    end
    win_len = '0;
    win_seq = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (port_id(p) == win_idx) begin
        win_len = len_in[LEN_W*p +: LEN_W];
        win_seq = seq_q[p];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      send            <= 1'b0;
      port_ID         <= '0;
      udp_tx_length   <= '0;
      sequence_number <= '0;
      grant           <= '0;
      timeout_err     <= 1'b0;
      rr_ptr_q        <= port_id(PORT_DDC0);
      seq_q           <= '0;
      tmo_q           <= '0;
      seq_sup_q       <= 1'b0;
    end else begin
      grant       <= '0;
      timeout_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            port_ID         <= win_idx;
            udp_tx_length   <= win_len;
            sequence_number <= win_seq;
            send            <= 1'b1;
            tmo_q           <= '0;
            seq_sup_q       <= seq_reset;
            state_q         <= StSend;
          end
        end
        StSend: begin
          if (seq_reset) begin
            seq_sup_q <= 1'b1;
          end
          if (udp_tx_active) begin
            send    <= 1'b0;
            state_q <= StDrain;
          end else if (tmo_q == TmoLast) begin
            // Abandon the packet: no grant and the counter keeps its value
            send        <= 1'b0;
            timeout_err <= 1'b1;
            state_q     <= StIdle;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        StDrain: begin
          if (seq_reset) begin
            seq_sup_q <= 1'b1;
          end
          if (!busy && !udp_tx_active) begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
              grant[p] <= (port_id(p) == port_ID);
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if ((port_id(p) == port_ID) && !seq_sup_q) begin
              seq_q[p] <= seq_q[p] + SEQ_W'(1);
            end
          end
          if (port_ID >= port_id(PORT_DDC0)) begin
            rr_ptr_q <= port_ID;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // A new run always restarts every counter, overriding any increment above
      if (seq_reset) begin
        seq_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Scoreboard bench for tx_packet_arbiter: a small send_data/UDP responder consumes each
// send, and the bench predicts port order, length and sequence number per packet.
module tb_tx_packet_arbiter;

  localparam int unsigned NP  = 8;
  localparam int unsigned TMO = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [NP-1:0]     req;
  logic [NP*16-1:0]  len_in;
  logic              seq_reset;
  logic              udp_tx_active;
  logic              busy;
  logic              send;
  logic [3:0]        port_ID;
  logic [15:0]       udp_tx_length;
  logic [31:0]       sequence_number;
  logic [NP-1:0]     grant;
  logic              timeout_err;

  tx_packet_arbiter #(
    .NUM_PORTS(NP),
    .TIMEOUT  (TMO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req            (req),
    .len_in         (len_in),
    .seq_reset      (seq_reset),
    .udp_tx_active  (udp_tx_active),
    .busy           (busy),
    .send           (send),
    .port_ID        (port_ID),
    .udp_tx_length  (udp_tx_length),
    .sequence_number(sequence_number),
    .grant          (grant),
    .timeout_err    (timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          port;
    logic [15:0] len;
    logic [31:0] seq;
  } pkt_t;

  pkt_t                 sb[$];
  logic [31:0]          mseq[NP];
  logic [15:0]          mlen[NP];
  int                   mrr;
  logic [NP-1:0][31:0]  frc_val;
  int                   n_checks = 0;
  int                   n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: fixed 0, 1, then walk upward from mrr+1 over 2..NP-1
  function automatic int pick(input logic [NP-1:0] m, input int rr);
    int n;
    int k;
    n = int'(NP) - 2;
    if (m[0]) return 0;
    if (m[1]) return 1;
    for (int d = 1; d <= n; d++) begin
      k = 2 + ((rr - 2 + d) % n);
      if (m[k]) return k;
    end
    return -1;
  endfunction

  task automatic push_pkt(input int p, input bit incr, input bit upd_rr);
    pkt_t e;
    e.port = p;
    e.len  = mlen[p];
    e.seq  = mseq[p];
    sb.push_back(e);
    if (incr) mseq[p] = mseq[p] + 32'd1;
    if (upd_rr && p >= 2) mrr = p;
  endtask

  task automatic push_all(input logic [NP-1:0] m);
    int w;
    while (m != '0) begin
      w = pick(m, mrr);
      push_pkt(w, 1'b1, 1'b1);
      m[w] = 1'b0;
    end
  endtask

  task automatic set_seq(input int p, input logic [31:0] v);
    mseq[p] = v;
    for (int i = 0; i < int'(NP); i++) frc_val[i] = mseq[i];
    force dut.seq_q = frc_val;
    @(negedge clock);
    release dut.seq_q;
  endtask

  // Acts as send_data + UDP stack for one packet and checks the whole handshake
  task automatic serve(input bit keep_req, input bit sr_pulse, input int max_wait);
    pkt_t          e;
    int            w;
    logic [NP-1:0] exp_g;
    w = 0;
    while (!send && w < max_wait) begin
      @(negedge clock);
      w++;
    end
    if (!send) begin
      check_val("send_wait", {63'd0, send}, 64'd1);
      return;
    end
    if (sb.size() == 0) begin
      check_val("sb_entries", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    check_val("port_ID", port_ID, e.port);
    check_val("udp_tx_length", udp_tx_length, e.len);
    check_val("sequence_number", sequence_number, e.seq);
    busy          = 1'b1;
    udp_tx_active = 1'b1;
    @(negedge clock);
    udp_tx_active = 1'b0;
    check_val("send_drop", send, 0);
    if (sr_pulse) begin
      seq_reset = 1'b1;
      for (int i = 0; i < int'(NP); i++) mseq[i] = '0;
    end
    @(negedge clock);
    seq_reset = 1'b0;
    check_val("send_drain", send, 0);
    @(negedge clock);
    busy  = 1'b0;
    exp_g = '0;
    exp_g[e.port] = 1'b1;
    w = 0;
    while (grant == '0 && w < 5) begin
      @(negedge clock);
      w++;
    end
    check_val("grant", grant, exp_g);
    if (!keep_req) req[e.port] = 1'b0;
    @(negedge clock);
    check_val("grant_pulse", grant, 0);
    check_val("send_gap", send, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    pkt_t e;
    int   w;
    int   cnt;
    reset         = 1'b1;
    req           = '0;
    seq_reset     = 1'b0;
    udp_tx_active = 1'b0;
    busy          = 1'b0;
    mrr           = 2;
    for (int p = 0; p < int'(NP); p++) begin
      mseq[p] = '0;
      mlen[p] = 16'(100 + 37 * p);
    end
    mlen[3] = 16'd1444;
    for (int p = 0; p < int'(NP); p++) len_in[16*p +: 16] = mlen[p];

    repeat (3) @(negedge clock);
    check_val("rst_outputs", {send, port_ID, udp_tx_length, sequence_number, grant, timeout_err}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_val("idle_no_send", send, 0);

    // Single request, one-cycle latency, then seq advances to 1
    req[3] = 1'b1;
    push_all(8'h08);
    serve(1'b0, 1'b0, 1);
    req[3] = 1'b1;
    push_all(8'h08);
    serve(1'b0, 1'b0, 1);

    // Fixed priority ahead of round-robin
    req = 8'h13;
    push_all(8'h13);
    repeat (3) serve(1'b0, 1'b0, 3);

    // Round-robin with all shared ports requesting continuously
    req = 8'hFC;
    for (int i = 0; i < 12; i++) push_pkt(pick(8'hFC, mrr), 1'b1, 1'b1);
    repeat (12) serve(1'b1, 1'b0, 3);
    req = '0;
    repeat (2) @(negedge clock);

    // Sequence wrap on port 5
    set_seq(5, 32'hFFFF_FFFF);
    req[5] = 1'b1;
    push_all(8'h20);
    serve(1'b0, 1'b0, 3);
    req[5] = 1'b1;
    push_all(8'h20);
    serve(1'b0, 1'b0, 3);

    // Bring port 2 to seq 7, then seq_reset during its DRAIN
    while (mseq[2] != 32'd7) begin
      req[2] = 1'b1;
      push_all(8'h04);
      serve(1'b0, 1'b0, 3);
    end
    req[2] = 1'b1;
    push_pkt(2, 1'b0, 1'b1);
    serve(1'b0, 1'b1, 3);
    req = 8'h4C;
    push_all(8'h4C);
    repeat (3) serve(1'b0, 1'b0, 3);

    // Timeout: no udp_tx_active, then the still-held request retries with the same seq
    req[4] = 1'b1;
    push_pkt(4, 1'b0, 1'b0);
    push_pkt(4, 1'b1, 1'b1);
    w = 0;
    while (!send && w < 3) begin
      @(negedge clock);
      w++;
    end
    check_val("tmo_send", send, 1);
    e = sb.pop_front();
    check_val("tmo_port", port_ID, e.port);
    check_val("tmo_seq", sequence_number, e.seq);
    cnt = 0;
    while (send && cnt < 40) begin
      @(negedge clock);
      cnt++;
    end
    check_val("tmo_cycles", cnt, TMO);
    check_val("tmo_err", timeout_err, 1);
    check_val("tmo_no_grant", grant, 0);
    @(negedge clock);
    check_val("tmo_err_pulse", timeout_err, 0);
    serve(1'b0, 1'b0, 3);

    // Asynchronous reset in the middle of SEND
    req[6] = 1'b1;
    w = 0;
    while (!send && w < 3) begin
      @(negedge clock);
      w++;
    end
    check_val("rst_sel_port", port_ID, 6);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_rst", {send, port_ID, udp_tx_length, sequence_number, grant, timeout_err}, 0);
    req = '0;
    mrr = 2;
    for (int i = 0; i < int'(NP); i++) mseq[i] = '0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    req = 8'h28;
    push_all(8'h28);
    repeat (2) serve(1'b0, 1'b0, 3);

    check_val("sb_drained", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
